// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between a datapath controller and the sequential divider.
// The controller holds the master modport; the divider holds the slave modport.
interface seq_divider_if #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
);
  logic               start;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               ready;
  logic               done;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, MSB first.
// Unsigned WIDTH_N / WIDTH_D with a start/done handshake and a divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_N-1:0] shift_q, shift_d;
  logic [WIDTH_N-1:0] quo_q,   quo_d;
  logic [WIDTH_D-1:0] dvsr_q,  dvsr_d;
  logic [WIDTH_D-1:0] prem_q,  prem_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic               dbz_q,   dbz_d;

  logic [WIDTH_D:0]   trial;
  logic [WIDTH_D-1:0] diff;
  logic               ge;

  // The stored remainder is always below the divisor, so WIDTH_D bits suffice;
  // the extra partial-remainder bit only exists transiently in trial.
  always_comb begin
    trial = {prem_q, shift_q[WIDTH_N-1]};
    ge    = (trial >= {1'b0, dvsr_q});
    diff  = trial[WIDTH_D-1:0] - dvsr_q;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.dividend;
          dvsr_d  = bus.divisor;
          prem_d  = '0;
          quo_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        shift_d = shift_q << 1;
        quo_d   = (quo_q << 1) | WIDTH_N'(ge);
        prem_d  = ge ? diff : trial[WIDTH_D-1:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH_N - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = prem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against plain integer division.
module tb_seq_divider;
  localparam int WN = 16;
  localparam int WD = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.WIDTH_N(WN), .WIDTH_D(WD)) bus();
  seq_divider #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation, returns cycles-to-done (-1 on timeout), the results seen
  // while done=1 and the results one cycle later; ends back in IDLE.
  task automatic run_op(input logic [WN-1:0] dvd, input logic [WD-1:0] dvs,
                        output int cyc, output logic [WN-1:0] q, output logic [WD-1:0] r,
                        output logic z, output logic [WN-1:0] qh, output logic [WD-1:0] rh);
    cyc = -1; q = '0; r = '0; z = 1'b0;
    bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.dividend = WN'($urandom); bus.divisor = WD'($urandom);
      if (bus.done) begin
        cyc = i; q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        break;
      end
    end
    @(posedge clk); #1;
    qh = bus.quotient; rh = bus.remainder;
  endtask

  task automatic test_reset;
    int cyc; logic [WN-1:0] q, qh; logic [WD-1:0] r, rh; logic z; int changes;
    run_op(16'd1000, 8'd7, cyc, q, r, z, qh, rh);
    #3 rst = 1'b1;
    #1;
    total++; if (bus.quotient !== 16'h0 || bus.remainder !== 8'h0) begin bad++;
      $display("FAIL reset_results: q=%h r=%h want 0 0", bus.quotient, bus.remainder); end
    total++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin bad++;
      $display("FAIL reset_flags: done=%b dbz=%b want 0 0", bus.done, bus.div_by_zero); end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready: got %b want 1", bus.ready); end
    changes = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 16'h0 ||
          bus.remainder !== 8'h0 || bus.div_by_zero !== 1'b0) changes++;
    end
    total++; if (changes !== 0) begin bad++;
      $display("FAIL idle_hold: %0d cycles changed, want 0", changes); end
  endtask

  task automatic test_directed;
    logic [WN-1:0] dv [4] = '{16'h03E8, 16'hFE01, 16'hFFFF, 16'h0005};
    logic [WD-1:0] ds [4] = '{8'h07,    8'hFF,    8'h01,    8'h09};
    logic [WN-1:0] eq [4] = '{16'h008E, 16'h00FF, 16'hFFFF, 16'h0000};
    logic [WD-1:0] er [4] = '{8'h06,    8'h00,    8'h00,    8'h05};
    int cyc; logic [WN-1:0] q, qh; logic [WD-1:0] r, rh; logic z;
    for (int k = 0; k < 4; k++) begin
      run_op(dv[k], ds[k], cyc, q, r, z, qh, rh);
      total++; if (cyc !== 17) begin bad++;
        $display("FAIL dir%0d_latency: got %0d want 17", k, cyc); end
      total++; if (q !== eq[k] || r !== er[k] || z !== 1'b0) begin bad++;
        $display("FAIL dir%0d_result: q=%h r=%h z=%b want %h %h 0", k, q, r, z, eq[k], er[k]); end
      total++; if (qh !== eq[k] || rh !== er[k]) begin bad++;
        $display("FAIL dir%0d_hold: q=%h r=%h want %h %h", k, qh, rh, eq[k], er[k]); end
    end
  endtask

  task automatic test_div_zero;
    int cyc; logic [WN-1:0] q, qh; logic [WD-1:0] r, rh; logic z;
    run_op(16'h1234, 8'h00, cyc, q, r, z, qh, rh);
    total++; if (cyc !== 1) begin bad++;
      $display("FAIL dbz_latency: got %0d want 1", cyc); end
    total++; if (q !== 16'hFFFF || r !== 8'h00 || z !== 1'b1) begin bad++;
      $display("FAIL dbz_result: q=%h r=%h z=%b want ffff 00 1", q, r, z); end
    total++; if (bus.div_by_zero !== 1'b1) begin bad++;
      $display("FAIL dbz_hold: got %b want 1", bus.div_by_zero); end
    run_op(16'd1000, 8'd7, cyc, q, r, z, qh, rh);
    total++; if (z !== 1'b0 || q !== 16'd142 || r !== 8'd6) begin bad++;
      $display("FAIL dbz_clear: q=%0d r=%0d z=%b want 142 6 0", q, r, z); end
  endtask

  task automatic test_busy;
    int ndone = 0;
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) ndone++;
      if (c == 5 || c == 17) begin
        bus.start = 1'b1; bus.dividend = 16'hFFFF; bus.divisor = 8'h01;
      end
      if (c == 17) begin
        total++; if (bus.done !== 1'b1 || bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
          bad++; $display("FAIL busy_result: done=%b q=%0d r=%0d want 1 142 6",
                          bus.done, bus.quotient, bus.remainder); end
      end
      if (c == 18) begin
        total++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin bad++;
          $display("FAIL busy_ready: ready=%b done=%b want 1 0", bus.ready, bus.done); end
      end
    end
    total++; if (ndone !== 1) begin bad++;
      $display("FAIL busy_pulses: got %0d want 1", ndone); end
  endtask

  task automatic test_reset_mid;
    int cyc, ndone; logic [WN-1:0] q, qh; logic [WD-1:0] r, rh; logic z;
    bus.start = 1'b1; bus.dividend = 16'hFE01; bus.divisor = 8'hFF;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1 bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.quotient !== 16'h0 || bus.remainder !== 8'h0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL mid_reset_out: q=%h r=%h done=%b want 0 0 0", bus.quotient, bus.remainder, bus.done); end
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    total++; if (ndone !== 0 || bus.ready !== 1'b1) begin bad++;
      $display("FAIL mid_reset_nodone: pulses=%0d ready=%b want 0 1", ndone, bus.ready); end
    run_op(16'd1000, 8'd7, cyc, q, r, z, qh, rh);
    total++; if (cyc !== 17 || q !== 16'd142 || r !== 8'd6) begin bad++;
      $display("FAIL mid_reset_recover: cyc=%0d q=%0d r=%0d want 17 142 6", cyc, q, r); end
  endtask

  task automatic test_random;
    int cyc; logic [WN-1:0] q, qh, dvd, eq; logic [WD-1:0] r, rh, dvs, er; logic z, ez;
    int ecyc; logic [WN+WD-1:0] recon;
    for (int k = 0; k < 300; k++) begin
      dvd = WN'($urandom);
      case ($urandom_range(0, 7))
        0: dvs = '0;
        1: dvs = WD'($urandom_range(1, 3));
        default: dvs = WD'($urandom);
      endcase
      if (k % 10 == 0) dvd = WN'($urandom_range(0, 300));
      if (dvs == '0) begin
        eq = '1; er = '0; ez = 1'b1; ecyc = 1;
      end else begin
        eq = dvd / WN'(dvs); er = WD'(dvd % WN'(dvs)); ez = 1'b0; ecyc = 17;
      end
      run_op(dvd, dvs, cyc, q, r, z, qh, rh);
      total++; if (cyc !== ecyc) begin bad++;
        $display("FAIL rnd%0d_latency: %h/%h got %0d want %0d", k, dvd, dvs, cyc, ecyc); end
      total++; if (q !== eq || r !== er || z !== ez) begin bad++;
        $display("FAIL rnd%0d_result: %h/%h q=%h r=%h z=%b want %h %h %b", k, dvd, dvs, q, r, z, eq, er, ez); end
      total++; if (qh !== eq || rh !== er) begin bad++;
        $display("FAIL rnd%0d_hold: q=%h r=%h want %h %h", k, qh, rh, eq, er); end
      if (dvs != '0) begin
        recon = (WN+WD)'(q) * (WN+WD)'(dvs) + (WN+WD)'(r);
        total++; if (recon !== (WN+WD)'(dvd) || !(r < dvs)) begin bad++;
          $display("FAIL rnd%0d_invariant: q*d+r=%h r=%h want %h r<%h", k, recon, r, dvd, dvs); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_div_zero;
    test_busy;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
